// File: rtl/checksum_stream_if.sv
// Word-in / checksum-out bundle for checksum_stream.
// master = upstream producer and checksum consumer; slave = checksum engine.
interface checksum_stream_if #(
   parameter int unsigned IN_DATA_WIDTH  = 17,
   parameter int unsigned OUT_DATA_WIDTH = 21,
   parameter int unsigned NUM_SEGS       = 8
);
   logic                      in_data_vld;
   logic                      in_data_rdy;
   logic [IN_DATA_WIDTH-1:0]  in_data;
   logic                      in_sof;
   logic                      in_eof;
   logic [NUM_SEGS-1:0]       seg_mask;
   logic                      mode;
   logic [OUT_DATA_WIDTH-1:0] out_data;
   logic                      out_data_vld;
   logic                      busy;

   modport master (
      output in_data_vld, in_data, in_sof, in_eof, seg_mask, mode,
      input  in_data_rdy, out_data, out_data_vld, busy
   );

   modport slave (
      input  in_data_vld, in_data, in_sof, in_eof, seg_mask, mode,
      output in_data_rdy, out_data, out_data_vld, busy
   );
endinterface

// File: rtl/checksum_stream.sv
// Frame-aware segmented checksum: each accepted word is walked one masked, shifted segment per
// cycle into a modulo or ones-complement accumulator; one checksum is emitted per frame.
module checksum_stream #(
   parameter int unsigned IN_DATA_WIDTH  = 17,
   parameter int unsigned OUT_DATA_WIDTH = 21,
   parameter int unsigned NUM_SEGS       = 8
) (
   input logic              clk,
   input logic              reset,
   checksum_stream_if.slave bus
);
   localparam int unsigned SEG_WIDTH = (IN_DATA_WIDTH + NUM_SEGS - 1) / NUM_SEGS;
   localparam int unsigned PAD_WIDTH = SEG_WIDTH * NUM_SEGS;
   localparam int unsigned IDX_WIDTH = $clog2(NUM_SEGS);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SEGS - 1);

   logic [0:0]                state_q;
   logic [PAD_WIDTH-1:0]      data_q;
   logic [NUM_SEGS-1:0]       mask_q;
   logic                      sof_q;
   logic                      eof_q;
   logic                      mode_q;
   logic [IDX_WIDTH-1:0]      idx_q;
   logic [OUT_DATA_WIDTH-1:0] acc_q;
   logic [OUT_DATA_WIDTH-1:0] out_data_q;
   logic                      out_vld_q;
   logic                      busy_q;

   logic [SEG_WIDTH-1:0]      seg;
   logic                      seg_en;
   logic [1:0]                shamt;
   logic [OUT_DATA_WIDTH-1:0] term;
   logic [OUT_DATA_WIDTH-1:0] base;
   logic [OUT_DATA_WIDTH:0]   sum;
   logic [OUT_DATA_WIDTH-1:0] acc_next;

   always_comb begin
      seg    = '0;
      seg_en = 1'b0;
      for (int i = 0; i < NUM_SEGS; i++) begin
         if (idx_q == IDX_WIDTH'(i)) begin
            seg    = data_q[i*SEG_WIDTH +: SEG_WIDTH];
            seg_en = mask_q[i];
         end
      end
      shamt = 2'(idx_q);
      term  = seg_en ? (OUT_DATA_WIDTH'(seg) << shamt) : '0;
      // First segment of an sof word starts from zero, dropping any partial frame.
      base  = (idx_q == '0 && sof_q) ? '0 : acc_q;
      sum   = {1'b0, base} + {1'b0, term};
      // End-around carry cannot overflow again: sum <= 2^(W+1)-2.
      acc_next = mode_q ? (sum[OUT_DATA_WIDTH-1:0] + OUT_DATA_WIDTH'(sum[OUT_DATA_WIDTH]))
                        : sum[OUT_DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         data_q     <= '0;
         mask_q     <= '0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         mode_q     <= 1'b0;
         idx_q      <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_vld_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         out_vld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.in_data_vld) begin
                  data_q  <= PAD_WIDTH'(bus.in_data);
                  mask_q  <= bus.seg_mask;
                  sof_q   <= bus.in_sof;
                  eof_q   <= bus.in_eof;
                  idx_q   <= '0;
                  state_q <= SCAN;
                  // Mode is latched per frame; stray words outside a frame take the live mode.
                  if (bus.in_sof || !busy_q) mode_q <= bus.mode;
                  if (bus.in_sof) busy_q <= 1'b1;
               end
            end
            default: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= IDLE;
                  if (eof_q) begin
                     out_data_q <= mode_q ? ~acc_next : acc_next;
                     out_vld_q  <= 1'b1;
                     acc_q      <= '0;
                     busy_q     <= 1'b0;
                  end else begin
                     acc_q <= acc_next;
                  end
               end else begin
                  acc_q <= acc_next;
                  idx_q <= idx_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.in_data_rdy  = (state_q == IDLE);
   assign bus.out_data     = out_data_q;
   assign bus.out_data_vld = out_vld_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_checksum_stream.sv
// Scoreboard bench for checksum_stream: a reference model queues expected frame checksums as
// words are sent; a negedge monitor pops and compares on every out_data_vld pulse.
module tb_checksum_stream;
   localparam int unsigned IW  = 17;
   localparam int unsigned OW  = 21;
   localparam int unsigned NS  = 8;
   localparam int unsigned SEG = (IW + NS - 1) / NS;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   pulses = 0;
   int   cyc = 0;

   longint          m_acc = 0;
   logic            m_mode = 1'b0;
   logic            m_open = 1'b0;
   logic [OW-1:0]   exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   checksum_stream_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .NUM_SEGS(NS)) bus ();
   checksum_stream_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(6), .NUM_SEGS(NS)) bus6 ();

   checksum_stream #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .NUM_SEGS(NS)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   checksum_stream #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(6), .NUM_SEGS(NS)) u_dut6 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus6)
   );

   // Reference: whole-word update in integer arithmetic.
   function automatic longint model_word(input longint acc, input logic [IW-1:0] d,
                                         input logic [NS-1:0] m, input logic s, input logic md,
                                         input int w);
      longint a = s ? 0 : acc;
      longint lim = longint'(1) << w;
      longint dd = longint'(d);
      for (int i = 0; i < NS; i++) begin
         longint sg = (dd >> (SEG * i)) & ((longint'(1) << SEG) - 1);
         if (m[i]) a = a + (sg << (i % 4));
         if (md) begin
            if (a >= lim) a = a - lim + 1;
         end else begin
            a = a % lim;
         end
      end
      return a;
   endfunction

   task automatic model_push(input logic [IW-1:0] d, input logic [NS-1:0] m, input logic s,
                             input logic e, input logic md);
      if (s || !m_open) m_mode = md;
      if (s) m_open = 1'b1;
      m_acc = model_word(m_acc, d, m, s, m_mode, OW);
      if (e) begin
         exp_q.push_back(m_mode ? OW'(~m_acc) : OW'(m_acc));
         m_acc  = 0;
         m_open = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (bus.out_data_vld === 1'b1) begin
         logic [OW-1:0] e;
         pulses++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse out_data=%0d required=no pulse", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin
               bad++;
               $display("FAIL scoreboard out_data=%0d required=%0d", bus.out_data, e);
            end
         end
      end
   end

   int last_acc = 0;

   task automatic send_word(input logic [IW-1:0] d, input logic [NS-1:0] m, input logic s,
                            input logic e, input logic md, input logic hold);
      int n = 0;
      @(negedge clk);
      bus.in_data_vld = 1'b1;
      bus.in_data     = d;
      bus.seg_mask    = m;
      bus.in_sof      = s;
      bus.in_eof      = e;
      bus.mode        = md;
      while (bus.in_data_rdy !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL send_timeout in_data_rdy=%b required=1", bus.in_data_rdy);
      end
      last_acc = cyc;
      model_push(d, m, s, e, md);
      @(negedge clk);
      if (!hold) bus.in_data_vld = 1'b0;
   endtask

   task automatic wait_pulse(output int k, output logic rdy_low);
      k = 0;
      rdy_low = 1'b1;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (bus.out_data_vld === 1'b1) break;
         if (bus.in_data_rdy !== 1'b0) rdy_low = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      total += 4;
      if (bus.in_data_rdy !== 1'b1) begin
         bad++; $display("FAIL reset_rdy got=%b required=1", bus.in_data_rdy);
      end
      if (bus.out_data !== '0) begin
         bad++; $display("FAIL reset_out_data got=%0d required=0", bus.out_data);
      end
      if (bus.out_data_vld !== 1'b0) begin
         bad++; $display("FAIL reset_vld got=%b required=0", bus.out_data_vld);
      end
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got=%b required=0", bus.busy);
      end
   endtask

   task automatic test_full_word;
      int   k;
      logic rl;
      send_word(17'h1FFFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_pulse(k, rl);
      total += 4;
      if (k != 8) begin bad++; $display("FAIL full_latency got=%0d required=8", k); end
      if (!rl) begin bad++; $display("FAIL full_rdy_low got=0 required=1"); end
      if (bus.in_data_rdy !== 1'b1) begin
         bad++; $display("FAIL full_rdy_back got=%b required=1", bus.in_data_rdy);
      end
      if (bus.out_data !== 21'd118) begin
         bad++; $display("FAIL full_mode0 got=%0d required=118", bus.out_data);
      end
      @(negedge clk);
      total += 2;
      if (bus.out_data_vld !== 1'b0) begin
         bad++; $display("FAIL pulse_width got=%b required=0", bus.out_data_vld);
      end
      if (bus.out_data !== 21'd118) begin
         bad++; $display("FAIL out_hold got=%0d required=118", bus.out_data);
      end
      send_word(17'h1FFFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_pulse(k, rl);
      total++;
      if (bus.out_data !== 21'd2097033) begin
         bad++; $display("FAIL full_mode1 got=%0d required=2097033", bus.out_data);
      end
   endtask

   task automatic test_zero_mask;
      int   k;
      logic rl;
      send_word(17'h1FFFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_pulse(k, rl);
      total += 2;
      if (k != 8) begin bad++; $display("FAIL zero_latency got=%0d required=8", k); end
      if (bus.out_data !== '0) begin
         bad++; $display("FAIL zero_mask got=%0d required=0", bus.out_data);
      end
   endtask

   task automatic test_narrow;
      logic [5:0] req[2] = '{6'd54, 6'd8};
      for (int md = 0; md < 2; md++) begin
         int k = 0;
         @(negedge clk);
         bus6.in_data_vld = 1'b1;
         bus6.in_data     = 17'h1FFFF;
         bus6.seg_mask    = 8'hFF;
         bus6.in_sof      = 1'b1;
         bus6.in_eof      = 1'b1;
         bus6.mode        = md[0];
         @(negedge clk);
         bus6.in_data_vld = 1'b0;
         while (bus6.out_data_vld !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
         end
         total++;
         if (bus6.out_data !== req[md] || k != 8) begin
            bad++;
            $display("FAIL narrow_mode%0d got=%0d@%0d required=%0d@8", md, bus6.out_data, k,
                     req[md]);
         end
      end
   endtask

   task automatic test_two_word_frame;
      int   k;
      int   p0;
      logic rl;
      logic busy_ok = 1'b1;
      p0 = pulses;
      send_word(17'h00007, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_sof got=%b required=1", bus.busy); end
      repeat (12) begin
         @(negedge clk);
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end
      send_word(17'h00038, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (bus.out_data_vld === 1'b1) break;
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end
      total += 3;
      if (!busy_ok) begin bad++; $display("FAIL busy_in_frame got=0 required=1"); end
      if (bus.out_data !== 21'd21) begin
         bad++; $display("FAIL two_word got=%0d required=21", bus.out_data);
      end
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_clear got=%b required=0", bus.busy); end
      repeat (3) @(negedge clk);
      total++;
      if (pulses != p0 + 1) begin
         bad++; $display("FAIL two_word_pulses got=%0d required=%0d", pulses - p0, 1);
      end
      rl = 1'b0;
   endtask

   task automatic test_back_to_back;
      int p0;
      int prev;
      int n = 0;
      p0 = pulses;
      for (int w = 0; w < 6; w++) begin
         prev = last_acc;
         send_word(IW'($urandom), NS'($urandom), 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         if (w > 0) begin
            total++;
            if (last_acc - prev != 9) begin
               bad++; $display("FAIL b2b_gap got=%0d required=9", last_acc - prev);
            end
         end
      end
      bus.in_data_vld = 1'b0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      total += 2;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_drain got=%0d required=0", exp_q.size());
      end
      if (pulses != p0 + 6) begin
         bad++; $display("FAIL b2b_pulses got=%0d required=6", pulses - p0);
      end
   endtask

   task automatic test_reset_mid_scan;
      int   k;
      logic rl;
      @(negedge clk);
      bus.in_data_vld = 1'b1;
      bus.in_data     = 17'h1FFFF;
      bus.seg_mask    = 8'hFF;
      bus.in_sof      = 1'b1;
      bus.in_eof      = 1'b1;
      bus.mode        = 1'b0;
      @(negedge clk);
      bus.in_data_vld = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_acc  = 0;
      m_open = 1'b0;
      total += 3;
      if (bus.out_data !== '0) begin
         bad++; $display("FAIL rst_mid_out got=%0d required=0", bus.out_data);
      end
      if (bus.in_data_rdy !== 1'b1) begin
         bad++; $display("FAIL rst_mid_rdy got=%b required=1", bus.in_data_rdy);
      end
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL rst_mid_busy got=%b required=0", bus.busy);
      end
      repeat (12) @(negedge clk);
      send_word(17'h00001, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_pulse(k, rl);
      total++;
      if (bus.out_data !== 21'd1) begin
         bad++; $display("FAIL rst_mid_next got=%0d required=1", bus.out_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset            = 1'b1;
      bus.in_data_vld  = 1'b0;
      bus.in_data      = '0;
      bus.seg_mask     = '0;
      bus.in_sof       = 1'b0;
      bus.in_eof       = 1'b0;
      bus.mode         = 1'b0;
      bus6.in_data_vld = 1'b0;
      bus6.in_data     = '0;
      bus6.seg_mask    = '0;
      bus6.in_sof      = 1'b0;
      bus6.in_eof      = 1'b0;
      bus6.mode        = 1'b0;
      test_reset();
      test_full_word();
      test_zero_mask();
      test_narrow();
      test_two_word_frame();
      test_back_to_back();
      test_reset_mid_scan();
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
